// File: rtl/uart_tx_arbiter_if.sv
// Requester / TX FIFO write-side bundle shared between the arbiter and its environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 10
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [DW-1:0]         fifo_din;

    // Arbiter side: accepts words from requesters and writes the FIFO.
    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_din
    );

    // Environment side: requesters and the TX FIFO.
    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter feeding one UART TX FIFO from NUM_REQ sources.
// A grantee keeps the FIFO until its last word or until MAX_LEN words (forced release).
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 10,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic                       clk_50mhz,
    input  logic                       n_rst,
    uart_tx_arbiter_if.master          bus,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    input  logic                       clr_err,
    output logic                       len_err
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   gnt_q;
    logic [CW-1:0]   beat_q;
    logic            len_err_q;

    logic [DW-1:0]   words [NUM_REQ];
    logic [IW-1:0]   pick_c;
    logic            any_c;
    logic            xfer_c;
    logic            last_c;
    logic            max_c;
    logic [IW-1:0]   next_rr_c;

    // Unpack the flattened requester data bus into one word per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = bus.req_data[i*DW +: DW];
    end

    // Round-robin scan: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        pick_c = '0;
        any_c  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!any_c && bus.req_valid[IW'(idx)]) begin
                any_c  = 1'b1;
                pick_c = IW'(idx);
            end
        end
    end

    // Word transfer qualifiers for the current grantee; writes follow fifo_full of this cycle only.
    always_comb begin
        xfer_c    = (state_q == S_XFER) && bus.req_valid[gnt_q] && !bus.fifo_full;
        last_c    = bus.req_last[gnt_q];
        max_c     = (beat_q == CW'(MAX_LEN - 1));
        next_rr_c = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + IW'(1);
    end

    // FIFO write port and requester handshake follow the transfer qualifier directly.
    always_comb begin
        bus.fifo_wr   = xfer_c;
        bus.req_ready = xfer_c ? (NUM_REQ'(1) << gnt_q) : '0;
        bus.fifo_din  = (state_q == S_XFER) ? words[gnt_q] : '0;
    end

    assign gnt_id  = gnt_q;
    assign busy    = (state_q == S_XFER);
    assign len_err = len_err_q;

    // Grant/transfer FSM with round-robin pointer, beat counter and sticky length error.
    always_ff @(posedge clk_50mhz or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            beat_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (clr_err) begin
                len_err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (any_c) begin
                        gnt_q   <= pick_c;
                        beat_q  <= '0;
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (xfer_c) begin
                        beat_q <= beat_q + CW'(1);
                        if (last_c) begin
                            state_q  <= S_IDLE;
                            rr_ptr_q <= next_rr_c;
                        end else if (max_c) begin
                            state_q   <= S_IDLE;
                            rr_ptr_q  <= next_rr_c;
                            len_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 10;
    localparam int unsigned ML = 4;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic          clk_50mhz = 1'b0;
    logic          n_rst;
    logic          clr_err;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          len_err;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .DW(DW), .MAX_LEN(ML)) u_dut (
        .clk_50mhz (clk_50mhz),
        .n_rst     (n_rst),
        .bus       (bus),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .clr_err   (clr_err),
        .len_err   (len_err)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int n_chk = 0;
    int n_err = 0;

    // Pending words per requester, each tagged with its end-of-message flag.
    word_t q [NR][$];

    // Reference model: who owns the FIFO (-1 = nobody), where the next scan starts,
    // the last granted index, words sent in the current message, and the sticky error.
    int m_owner;
    int m_rr;
    int m_gnt;
    int m_cnt;
    bit m_err;

    logic [NR-1:0] hold_off;
    logic [DW-1:0] drv_d [NR];
    logic [NR-1:0] drv_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_gnt   = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic push_words(input int r, input int n, input logic [DW-1:0] base, input bit end_last);
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.d = base + DW'(k);
            w.l = end_last && (k == n - 1);
            q[r].push_back(w);
        end
    endtask

    // One clock: drive requesters, compare every output against the model, advance the model.
    task automatic step(input int full_pct, input int drop_pct, input int clr_pct);
        logic          full;
        logic          clr;
        logic [NR-1:0] lst;
        logic          can;
        bit            rel;
        bit            set;
        logic [DW-1:0] exp_din;
        logic [NR-1:0] exp_rdy;
        @(negedge clk_50mhz);
        for (int i = 0; i < NR; i++) begin
            if (q[i].size() > 0) begin
                drv_v[i] = (32'($urandom_range(99)) >= 32'(drop_pct)) && !hold_off[i];
                drv_d[i] = q[i][0].d;
                lst[i]   = q[i][0].l;
            end else begin
                drv_v[i] = 1'b0;
                drv_d[i] = DW'($urandom);
                lst[i]   = 1'($urandom);
            end
            bus.req_data[i*DW +: DW] = drv_d[i];
        end
        full          = 32'($urandom_range(99)) < 32'(full_pct);
        clr           = 32'($urandom_range(99)) < 32'(clr_pct);
        bus.req_valid = drv_v;
        bus.req_last  = lst;
        bus.fifo_full = full;
        clr_err       = clr;
        #2;
        can     = (m_owner >= 0) && drv_v[m_owner] && !full;
        exp_din = (m_owner >= 0) ? drv_d[m_owner] : '0;
        exp_rdy = can ? (NR'(1) << m_owner) : '0;
        check("fifo_wr",   32'(bus.fifo_wr),   32'(can));
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("fifo_din",  32'(bus.fifo_din),  32'(exp_din));
        check("busy",      32'(busy),          32'(m_owner >= 0));
        check("gnt_id",    32'(gnt_id),        32'(m_gnt));
        check("len_err",   32'(len_err),       32'(m_err));
        rel = 1'b0;
        set = 1'b0;
        if (can) begin
            word_t w;
            w = q[m_owner].pop_front();
            m_cnt++;
            if (w.l) begin
                rel = 1'b1;
            end else if (m_cnt == ML) begin
                rel = 1'b1;
                set = 1'b1;
            end
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (rel) begin
            m_rr    = (m_owner + 1) % NR;
            m_owner = -1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_rr + k) % NR;
                if (m_owner < 0 && drv_v[idx]) begin
                    m_owner = idx;
                    m_gnt   = idx;
                    m_cnt   = 0;
                end
            end
        end
    endtask

    // Asynchronous reset between clock edges; outputs must drop before the next edge.
    task automatic mid_reset();
        #3;
        n_rst = 1'b0;
        #1;
        check("rst_fifo_wr",   32'(bus.fifo_wr),   32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_gnt_id",    32'(gnt_id),        32'd0);
        check("rst_len_err",   32'(len_err),       32'd0);
        model_reset();
        bus.req_valid = '0;
        @(negedge clk_50mhz);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst         = 1'b0;
        clr_err       = 1'b0;
        hold_off      = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        model_reset();
        #25;
        check("reset_fifo_wr",   32'(bus.fifo_wr),   32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_fifo_din",  32'(bus.fifo_din),  32'd0);
        check("reset_busy",      32'(busy),          32'd0);
        check("reset_gnt_id",    32'(gnt_id),        32'd0);
        check("reset_len_err",   32'(len_err),       32'd0);
        @(negedge clk_50mhz);
        n_rst = 1'b1;

        // Single three-word message from requester 0.
        push_words(0, 3, 10'h041, 1'b1);
        repeat (6) step(0, 0, 0);

        // Requesters 0, 1 and 3 compete with two-word messages.
        push_words(0, 2, 10'h080, 1'b1);
        push_words(1, 2, 10'h090, 1'b1);
        push_words(3, 2, 10'h0B0, 1'b1);
        push_words(0, 2, 10'h084, 1'b1);
        repeat (14) step(0, 0, 0);

        // FIFO full for five cycles in the middle of requester 2's message.
        push_words(2, 5, 10'h120, 1'b1);
        repeat (3) step(0, 0, 0);
        repeat (5) step(100, 0, 0);
        repeat (6) step(0, 0, 0);

        // Requester 1 streams six words with no last: forced release, regrant, then clear.
        push_words(1, 6, 10'h200, 1'b0);
        repeat (10) step(0, 0, 0);
        push_words(1, 1, 10'h206, 1'b1);
        repeat (3) step(0, 0, 0);
        step(0, 0, 100);
        repeat (2) step(0, 0, 0);

        // Reset while requester 0's second word is on the bus, then requester 2 alone.
        push_words(3, 1, 10'h2F0, 1'b1);
        repeat (3) step(0, 0, 0);
        push_words(0, 4, 10'h300, 1'b1);
        repeat (3) step(0, 0, 0);
        mid_reset();
        for (int i = 0; i < NR; i++) q[i].delete();
        push_words(2, 2, 10'h320, 1'b1);
        repeat (5) step(0, 0, 0);

        // Requester 3 pauses mid-message while requester 0 waits.
        push_words(3, 4, 10'h340, 1'b1);
        repeat (3) step(0, 0, 0);
        push_words(0, 2, 10'h360, 1'b1);
        hold_off = 4'b1000;
        repeat (3) step(0, 0, 0);
        hold_off = '0;
        repeat (8) step(0, 0, 0);

        // Randomized traffic with back-pressure, valid gaps, error clears and resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 12) begin
                int r;
                r = int'($urandom_range(NR - 1));
                if (q[r].size() < 12)
                    push_words(r, int'($urandom_range(6, 1)), DW'($urandom), 1'($urandom_range(3) != 0));
            end
            step(20, 15, 4);
            if (c % 997 == 500) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
